operand_fetch_seq: RTL and testbench
====================================

// Module: operand_fetch_seq
// PURPOSE
//   Upstream controller for the single-port operand ROM (negedge-read, 1-cycle visible latency).
//   - Walks a ROM window two words at a time and reads operand A at addr and operand B at addr+1.
//   - Presents each {op_a, op_b} pair to the arithmetic datapath over a valid/ready handshake.
//   - Reports busy, done and the index of the current pair.
// PARAMETERS
//   ADDRESS_WIDTH  7   ROM address width; must match the ROM instance
//   DATA_WIDTH     16  ROM word width = operand width
//   COUNT_WIDTH    6   width of pair_count / pair_index
// PORTS
//   clk          in   1               system clock, rising edge (the ROM samples on the falling edge)
//   reset        in   1               asynchronous, active-high; also drives the ROM reset
//   start        in   1               1-cycle request to begin a run; ignored unless idle
//   base_addr    in   ADDRESS_WIDTH   first ROM address of the run
//   pair_count   in   COUNT_WIDTH     number of operand pairs to fetch
//   rom_address  out  ADDRESS_WIDTH   to ROM sink_address
//   rom_ren      out  1               to ROM sink_ren
//   rom_cen      out  1               to ROM sink_cen
//   rom_data     in   DATA_WIDTH      from ROM src_data
//   op_a         out  DATA_WIDTH      operand A of the presented pair
//   op_b         out  DATA_WIDTH      operand B of the presented pair
//   out_valid    out  1               pair on op_a/op_b is valid
//   out_ready    in   1               downstream accepts the pair when out_valid && out_ready
//   pair_index   out  COUNT_WIDTH     0-based index of the presented pair
//   busy         out  1               high in every state except IDLE
//   done         out  1               1-cycle pulse when a run ends
// BEHAVIOUR
//   Reset (async, immediate)
//   - All outputs go to 0. FSM goes to IDLE. Internal addr/remaining registers go to 0.
//   - Reset asserted mid-run aborts the run; no pair is emitted and no done pulse is given.
//   - Reset must be held >= 1 full clk period so the ROM reloads its image on a falling edge.
//   FSM: IDLE -> RD_A -> RD_B -> PRESENT -> (RD_A | FINISH) -> IDLE
//   - IDLE: rom_cen = rom_ren = 0.
//       start && pair_count != 0: latch addr <= base_addr, remaining <= pair_count, pair_index <= 0; go RD_A.
//       start && pair_count == 0: go FINISH (done pulses, no ROM access).
//   - RD_A: rom_address = addr, rom_cen = rom_ren = 1; go RD_B.
//   - RD_B: rom_address = addr+1 (mod 2^ADDRESS_WIDTH), cen = ren = 1.
//       op_a <= rom_data on the rising edge that enters RD_B; go PRESENT.
//   - PRESENT: cen = ren = 0.
//       op_b <= rom_data on the rising edge that enters PRESENT.
//       out_valid = 1; op_a, op_b and pair_index stay stable until accepted.
//       On accept with remaining > 1: remaining -= 1, addr += 2 (mod 2^ADDRESS_WIDTH), pair_index += 1; go RD_A.
//       On accept with remaining == 1: go FINISH.
//   - FINISH: done = 1 for exactly one cycle; busy = 1; go IDLE.
//   Timing and edge cases
//   - Latency: if start is high in cycle c, the first out_valid appears in cycle c+3.
//     Each further pair takes 3 cycles plus downstream stall cycles.
//   - out_valid drops in the cycle after the accepting edge. No pair is ever emitted twice.
//   - Address wrap: with addr = 2^ADDRESS_WIDTH-1, operand B is read from address 0.
//     The run then continues from address 1.
//   - start while busy: ignored; inputs are not re-latched.
//   - start coinciding with the FINISH cycle: ignored.
//   - base_addr / pair_count changing mid-run has no effect.
//   - ROM data is never sampled while the ROM is in reset; its all-ones reset word never reaches op_a/op_b.
// STRUCTURE
//   - Shared include fetch_defs.vh:
//       FSM state localparams IDLE/RD_A/RD_B/PRESENT/FINISH, 3-bit encoded;
//       ROM_READ_LATENCY = 1.
//   - Sub-module rom_addr_gen: loadable ADDRESS_WIDTH counter with +1 and +2 steps.
//       Provides the RD_B offset and the per-pair advance; wraps modulo 2^ADDRESS_WIDTH.
//   - All remaining logic lives in this module.
// TESTING (bench instantiates the real ROM with a known hex image, mem[i] = 16'h1000+i)
//   1. reset 2 cycles, then base=4, count=1, out_ready=1
//      -> op_a=16'h1004, op_b=16'h1005, out_valid in cycle c+3, done 1 cycle later, busy low after.
//   2. base=10, count=3, out_ready=1
//      -> pairs (100A,100B), (100C,100D), (100E,100F); pair_index 0,1,2; single done pulse.
//   3. base=126, count=2 (ADDRESS_WIDTH=7)
//      -> pairs (107E,107F), (1000,1001); wrap is correct.
//   4. out_ready held low 5 cycles in PRESENT
//      -> out_valid, op_a, op_b and pair_index stable; rom_cen=0 throughout; accepted once on release.
//   5. count=0 -> no ROM access, done pulses once; a second start while busy in scenario 2 -> ignored.
//   6. reset asserted in RD_B mid-run
//      -> all outputs 0 immediately; a new start after release begins cleanly from the new base.

Source files
------------

// File: rtl/operand_fetch_seq_pkg.sv
// Shared definitions for the operand fetch sequencer: FSM state type and ROM timing.
package operand_fetch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    PRESENT,
    FINISH
  } fetch_state_t;

  localparam int unsigned ROM_READ_LATENCY = 1;

endpackage

// File: rtl/rom_addr_gen.sv
// Loadable ROM address counter; exposes the +1 (operand B) and +2 (next pair) addresses.
module rom_addr_gen #(
  parameter int unsigned ADDRESS_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     advance,
  input  logic [ADDRESS_WIDTH-1:0] load_value,
  output logic [ADDRESS_WIDTH-1:0] addr_plus1,
  output logic [ADDRESS_WIDTH-1:0] addr_plus2
);

  logic [ADDRESS_WIDTH-1:0] addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_value;
    end else if (advance) begin
      addr <= addr_plus2;
    end
  end

  // Truncation to ADDRESS_WIDTH gives the modulo-2^ADDRESS_WIDTH wrap.
  always_comb begin
    addr_plus1 = addr + ADDRESS_WIDTH'(1);
    addr_plus2 = addr + ADDRESS_WIDTH'(2);
  end

endmodule

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: reads {A,B} word pairs from a negedge-read ROM and
// presents them to the datapath over valid/ready, with busy/done/index status.
module operand_fetch_seq
  import operand_fetch_seq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 7,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned COUNT_WIDTH   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]   pair_count,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  output logic                     rom_ren,
  output logic                     rom_cen,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [DATA_WIDTH-1:0]    op_a,
  output logic [DATA_WIDTH-1:0]    op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COUNT_WIDTH-1:0]   pair_index,
  output logic                     busy,
  output logic                     done
);

  fetch_state_t             state;
  logic [COUNT_WIDTH-1:0]   remaining;
  logic [ADDRESS_WIDTH-1:0] addr_plus1;
  logic [ADDRESS_WIDTH-1:0] addr_plus2;
  logic                     launch;
  logic                     accept;
  logic                     advance;

  always_comb begin
    launch  = (state == IDLE) && start && (pair_count != '0);
    accept  = (state == PRESENT) && out_ready;
    advance = accept && (remaining > COUNT_WIDTH'(1));
  end

  rom_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (launch),
    .advance    (advance),
    .load_value (base_addr),
    .addr_plus1 (addr_plus1),
    .addr_plus2 (addr_plus2)
  );

  // Outputs are registered, so ROM controls are set up on the edge that
  // enters each read state; the ROM samples them on the following falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      rom_address <= '0;
      rom_ren     <= 1'b0;
      rom_cen     <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      out_valid   <= 1'b0;
      pair_index  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (pair_count != '0) begin
              remaining   <= pair_count;
              pair_index  <= '0;
              rom_address <= base_addr;
              rom_cen     <= 1'b1;
              rom_ren     <= 1'b1;
              state       <= RD_A;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        RD_A: begin
          op_a        <= rom_data;
          rom_address <= addr_plus1;
          state       <= RD_B;
        end
        RD_B: begin
          op_b      <= rom_data;
          rom_cen   <= 1'b0;
          rom_ren   <= 1'b0;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (advance) begin
              remaining   <= remaining - COUNT_WIDTH'(1);
              pair_index  <= pair_index + COUNT_WIDTH'(1);
              rom_address <= addr_plus2;
              rom_cen     <= 1'b1;
              rom_ren     <= 1'b1;
              state       <= RD_A;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          rom_cen   <= 1'b0;
          rom_ren   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Randomized self-checking bench for operand_fetch_seq with a behavioural ROM (mem[i] = 16'h1000+i).
module tb_operand_fetch_seq;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] pair_count = '0;
  logic [AW-1:0] rom_address;
  logic          rom_ren;
  logic          rom_cen;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] pair_index;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [CW-1:0] idx;
  } pair_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  operand_fetch_seq #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .pair_count (pair_count),
    .rom_address(rom_address),
    .rom_ren    (rom_ren),
    .rom_cen    (rom_cen),
    .rom_data   (rom_data),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pair_index (pair_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h1000 + 16'(i);
  end

  // Single-port ROM: reads on the falling edge, all-ones word while in reset.
  always @(negedge clk) begin
    if (reset) rom_data <= '1;
    else if (rom_cen && rom_ren) rom_data <= mem[rom_address];
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
  end

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({rom_address, rom_ren, rom_cen, op_a, op_b, out_valid, pair_index, busy, done});
  endfunction

  task automatic run_case(input logic [AW-1:0] base, input logic [CW-1:0] count,
                          input int stall_pct, input int hold_first, input bit extra_start);
    pair_t         exp_q[$];
    pair_t         p;
    logic [AW-1:0] a;
    int            cycle;
    int            valid_seen;
    int            dones_before;
    bit            seen_valid;
    bit            finished;
    bit            prev_accept;
    bit            prev_pending;

    for (int k = 0; k < int'(count); k++) begin
      a     = base + AW'(2 * k);
      p.a   = mem[a];
      a     = a + AW'(1);
      p.b   = mem[a];
      p.idx = CW'(k);
      exp_q.push_back(p);
    end

    dones_before = done_pulses;
    start        = 1'b1;
    base_addr    = base;
    pair_count   = count;
    out_ready    = 1'b0;
    @(posedge clk); #1;
    start        = 1'b0;
    base_addr    = AW'($urandom);
    pair_count   = CW'($urandom);
    cycle        = 1;
    valid_seen   = 0;
    seen_valid   = 1'b0;
    finished     = 1'b0;
    prev_accept  = 1'b0;
    prev_pending = 1'b0;

    while (!finished && cycle < 400) begin
      check_eq("busy_run", busy, 1);
      if (count == 0) check_eq("no_rom_access", rom_cen | rom_ren, 0);
      if (prev_accept) check_eq("valid_drop", out_valid, 0);
      if (prev_pending) check_eq("valid_hold", out_valid, 1);
      if (out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check_eq("latency", cycle, 3);
        end
        check_eq("cen_present", rom_cen, 0);
        if (exp_q.size() == 0) begin
          check_eq("extra_pair", out_valid, 0);
        end else begin
          check_eq("op_a", op_a, exp_q[0].a);
          check_eq("op_b", op_b, exp_q[0].b);
          check_eq("pair_index", pair_index, exp_q[0].idx);
        end
        valid_seen++;
        out_ready = (valid_seen > hold_first) && (int'($urandom_range(99)) >= stall_pct);
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      prev_accept  = out_valid && out_ready;
      prev_pending = out_valid && !out_ready;
      if (prev_accept && exp_q.size() > 0) void'(exp_q.pop_front());
      if (done) begin
        finished = 1'b1;
        check_eq("pairs_left", exp_q.size(), 0);
      end
      // start during FINISH or mid-run must be ignored
      start      = done || (extra_start && cycle == 2);
      base_addr  = AW'($urandom);
      pair_count = CW'($urandom_range(1, 9));
      @(posedge clk); #1;
      cycle++;
    end
    if (!finished) check_eq("timeout", finished, 1);
    start = 1'b0;
    check_eq("busy_after", busy, 0);
    check_eq("done_after", done, 0);
    check_eq("valid_after", out_valid, 0);
    check_eq("done_count", done_pulses - dones_before, 1);
    @(posedge clk); #1;
    check_eq("idle_stays", busy, 0);
  endtask

  initial begin
    int pulses_before;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_after_reset", all_outputs(), 0);

    run_case(7'd4,   6'd1, 0, 0, 1'b0);
    run_case(7'd10,  6'd3, 0, 0, 1'b1);
    run_case(7'd126, 6'd2, 0, 0, 1'b0);
    run_case(7'd127, 6'd2, 0, 0, 1'b0);
    run_case(7'd30,  6'd2, 0, 5, 1'b0);
    run_case(7'd50,  6'd0, 0, 0, 1'b0);

    // Reset while reading operand B aborts the run with no done pulse.
    pulses_before = done_pulses;
    start      = 1'b1;
    base_addr  = 7'd20;
    pair_count = 6'd3;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("abort_outputs", all_outputs(), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_held", all_outputs(), 0);
    reset = 1'b0;
    check_eq("abort_no_done", done_pulses - pulses_before, 0);
    @(posedge clk); #1;
    run_case(7'd40, 6'd2, 20, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_case(AW'($urandom), CW'($urandom_range(1, 5)), int'($urandom_range(0, 60)), 0,
               $urandom_range(1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
